// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_pkg
// Description : Shared state encodings, frame constants and opcodes for the
//               UART command frame parser and the register block it feeds.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_SYNC   = 3'd0,
    ST_OPCODE = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHECK  = 3'd4
  } state_e;

  localparam logic [7:0] C_SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         C_FRAME_BYTES       = 5;

  // Opcodes understood by the downstream register/control block.
  localparam logic [7:0] C_OP_NOP   = 8'h00;
  localparam logic [7:0] C_OP_WRITE = 8'h01;
  localparam logic [7:0] C_OP_READ  = 8'h02;
  localparam logic [7:0] C_OP_RESET = 8'h07;

endpackage : uart_cmd_pkg
`default_nettype wire

// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_parser
// Description : Assembles 5-byte sync/opcode/addr/data/checksum frames from a
//               UART byte stream and emits a command or error strobe.
//               Optional idle timeout: define UART_CMD_PARSER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = C_SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CLOCKS = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       cmd_valid_o,
  output logic [7:0] cmd_opcode_o,
  output logic [7:0] cmd_addr_o,
  output logic [7:0] cmd_data_o,
  output logic       err_o,
  output logic       busy_o
);

  state_e     state_q, state_d;
  logic [7:0] op_q, op_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic [7:0] sum_q, sum_d;
  logic       cmd_valid_q, cmd_valid_d;
  logic       err_q, err_d;
  logic [7:0] out_op_q, out_op_d;
  logic [7:0] out_addr_q, out_addr_d;
  logic [7:0] out_data_q, out_data_d;
  logic       w_tmo_expire;

`ifdef UART_CMD_PARSER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLOCKS);
  localparam logic [TW-1:0] C_TMO_MAX = TW'(TIMEOUT_CLOCKS - 1);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  // A byte arriving on the expiry cycle wins, so expiry is qualified by !valid_i.
  assign w_tmo_expire = (state_q != ST_SYNC) && !valid_i && (tmo_cnt_q == C_TMO_MAX);

  always_comb begin
    tmo_cnt_d = tmo_cnt_q + 1'b1;
    if (valid_i || (state_q == ST_SYNC) || w_tmo_expire) begin
      tmo_cnt_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CLOCKS > 0);
  assign w_tmo_expire = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    data_d      = data_q;
    sum_d       = sum_q;
    cmd_valid_d = 1'b0;
    err_d       = 1'b0;
    out_op_d    = out_op_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;

    if (valid_i) begin
      case (state_q)
        ST_SYNC: begin
          if (data_i == SYNC_BYTE) begin
            state_d = ST_OPCODE;
            sum_d   = '0;
          end
        end
        ST_OPCODE: begin
          op_d    = data_i;
          sum_d   = data_i;
          state_d = ST_ADDR;
        end
        ST_ADDR: begin
          addr_d  = data_i;
          sum_d   = sum_q + data_i;
          state_d = ST_DATA;
        end
        ST_DATA: begin
          data_d  = data_i;
          sum_d   = sum_q + data_i;
          state_d = ST_CHECK;
        end
        ST_CHECK: begin
          if (data_i == sum_q) begin
            cmd_valid_d = 1'b1;
            out_op_d    = op_q;
            out_addr_d  = addr_q;
            out_data_d  = data_q;
          end else begin
            err_d = 1'b1;
          end
          state_d = ST_SYNC;
        end
        default: state_d = ST_SYNC;
      endcase
    end else if (w_tmo_expire) begin
      state_d = ST_SYNC;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_SYNC;
      op_q        <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      sum_q       <= '0;
      cmd_valid_q <= 1'b0;
      err_q       <= 1'b0;
      out_op_q    <= '0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      sum_q       <= sum_d;
      cmd_valid_q <= cmd_valid_d;
      err_q       <= err_d;
      out_op_q    <= out_op_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
    end
  end

  assign cmd_valid_o  = cmd_valid_q;
  assign err_o        = err_q;
  assign cmd_opcode_o = out_op_q;
  assign cmd_addr_o   = out_addr_q;
  assign cmd_data_o   = out_data_q;
  assign busy_o       = (state_q != ST_SYNC);

endmodule : uart_cmd_parser
`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_parser
// Description : Directed self-checking bench for uart_cmd_parser; the idle
//               timeout steps run only with UART_CMD_PARSER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_parser;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] data_i;
  logic       valid_i;
  logic       cmd_valid_o;
  logic [7:0] cmd_opcode_o;
  logic [7:0] cmd_addr_o;
  logic [7:0] cmd_data_o;
  logic       err_o;
  logic       busy_o;

  int n_cmp   = 0;
  int n_fail  = 0;
  int n_cmd   = 0;
  int n_errp  = 0;
  int c0, e0;

  uart_cmd_parser #(
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CLOCKS (16)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .data_i       (data_i),
    .valid_i      (valid_i),
    .cmd_valid_o  (cmd_valid_o),
    .cmd_opcode_o (cmd_opcode_o),
    .cmd_addr_o   (cmd_addr_o),
    .cmd_data_o   (cmd_data_o),
    .err_o        (err_o),
    .busy_o       (busy_o)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs read here reflect the last rising edge.
  task automatic drive(input logic [7:0] b, input logic v);
    @(negedge clock);
    data_i  = b;
    valid_i = v;
  endtask

  task automatic send5(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input logic [7:0] b3, input logic [7:0] b4);
    drive(b0, 1'b1);
    drive(b1, 1'b1);
    drive(b2, 1'b1);
    drive(b3, 1'b1);
    drive(b4, 1'b1);
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (cmd_valid_o) n_cmd++;
      if (err_o)       n_errp++;
      if (cmd_valid_o || err_o) chk("strobe_exclusive", {31'd0, cmd_valid_o & err_o}, 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] b2b [10];

  initial begin
    reset   = 1'b1;
    valid_i = 1'b0;
    data_i  = 8'h00;
    repeat (3) @(negedge clock);
    chk("rst_cmd_valid", {31'd0, cmd_valid_o}, 32'd0);
    chk("rst_err",       {31'd0, err_o},       32'd0);
    chk("rst_opcode",    {24'd0, cmd_opcode_o}, 32'h00);
    chk("rst_addr",      {24'd0, cmd_addr_o},   32'h00);
    chk("rst_data",      {24'd0, cmd_data_o},   32'h00);
    chk("rst_busy",      {31'd0, busy_o},      32'd0);
    reset = 1'b0;
    drive(8'h00, 1'b0);

    // Good frame
    send5(8'hA5, 8'h01, 8'h10, 8'h22, 8'h33);
    chk("good_busy_mid", {31'd0, busy_o}, 32'd1);
    drive(8'h00, 1'b0);
    chk("good_cmd_valid", {31'd0, cmd_valid_o}, 32'd1);
    chk("good_err",       {31'd0, err_o},       32'd0);
    chk("good_opcode",    {24'd0, cmd_opcode_o}, 32'h01);
    chk("good_addr",      {24'd0, cmd_addr_o},   32'h10);
    chk("good_data",      {24'd0, cmd_data_o},   32'h22);
    chk("good_busy_end",  {31'd0, busy_o},      32'd0);
    drive(8'h00, 1'b0);
    chk("good_one_cycle", {31'd0, cmd_valid_o}, 32'd0);

    // Bad checksum keeps previous fields
    drive(8'h00, 1'b0);
    c0 = n_cmd; e0 = n_errp;
    send5(8'hA5, 8'h01, 8'h10, 8'h22, 8'h34);
    drive(8'h00, 1'b0);
    chk("bad_err",       {31'd0, err_o},       32'd1);
    chk("bad_cmd_valid", {31'd0, cmd_valid_o}, 32'd0);
    chk("bad_opcode",    {24'd0, cmd_opcode_o}, 32'h01);
    chk("bad_addr",      {24'd0, cmd_addr_o},   32'h10);
    chk("bad_data",      {24'd0, cmd_data_o},   32'h22);
    drive(8'h00, 1'b0);
    chk("bad_err_one_cycle", {31'd0, err_o}, 32'd0);
    drive(8'h00, 1'b0);
    chk("bad_err_count", n_errp - e0, 32'd1);
    chk("bad_cmd_count", n_cmd - c0,  32'd0);

    // Junk before sync
    e0 = n_errp;
    drive(8'h00, 1'b1);
    drive(8'hFF, 1'b1);
    drive(8'h5A, 1'b1);
    drive(8'h00, 1'b0);
    chk("junk_busy", {31'd0, busy_o}, 32'd0);
    send5(8'hA5, 8'h02, 8'h03, 8'h04, 8'h09);
    drive(8'h00, 1'b0);
    chk("junk_cmd_valid", {31'd0, cmd_valid_o}, 32'd1);
    chk("junk_opcode",    {24'd0, cmd_opcode_o}, 32'h02);
    chk("junk_addr",      {24'd0, cmd_addr_o},   32'h03);
    chk("junk_data",      {24'd0, cmd_data_o},   32'h04);
    drive(8'h00, 1'b0);
    drive(8'h00, 1'b0);
    chk("junk_no_err", n_errp - e0, 32'd0);

    // Reset mid-frame
    c0 = n_cmd; e0 = n_errp;
    drive(8'hA5, 1'b1);
    drive(8'h01, 1'b1);
    @(negedge clock);
    valid_i = 1'b0;
    reset   = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("rstmid_busy", {31'd0, busy_o}, 32'd0);
    chk("rstmid_cmd_valid", {31'd0, cmd_valid_o}, 32'd0);
    send5(8'hA5, 8'h07, 8'h00, 8'h00, 8'h07);
    drive(8'h00, 1'b0);
    chk("rstmid_cmd_valid2", {31'd0, cmd_valid_o}, 32'd1);
    chk("rstmid_opcode",     {24'd0, cmd_opcode_o}, 32'h07);
    chk("rstmid_addr",       {24'd0, cmd_addr_o},   32'h00);
    chk("rstmid_data",       {24'd0, cmd_data_o},   32'h00);
    drive(8'h00, 1'b0);
    drive(8'h00, 1'b0);
    chk("rstmid_cmd_count", n_cmd - c0,  32'd1);
    chk("rstmid_err_count", n_errp - e0, 32'd0);

    // Back-to-back frames; second checksum wraps 0x2FD -> 0xFD
    c0 = n_cmd;
    b2b = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h06, 8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFD};
    for (int i = 0; i < 10; i++) begin
      drive(b2b[i], 1'b1);
      if (i == 5) begin
        chk("b2b1_cmd_valid", {31'd0, cmd_valid_o}, 32'd1);
        chk("b2b1_opcode",    {24'd0, cmd_opcode_o}, 32'h01);
        chk("b2b1_addr",      {24'd0, cmd_addr_o},   32'h02);
        chk("b2b1_data",      {24'd0, cmd_data_o},   32'h03);
      end
    end
    drive(8'h00, 1'b0);
    chk("b2b2_cmd_valid", {31'd0, cmd_valid_o}, 32'd1);
    chk("b2b2_opcode",    {24'd0, cmd_opcode_o}, 32'hFF);
    chk("b2b2_addr",      {24'd0, cmd_addr_o},   32'hFF);
    chk("b2b2_data",      {24'd0, cmd_data_o},   32'hFF);
    drive(8'h00, 1'b0);
    drive(8'h00, 1'b0);
    chk("b2b_cmd_count", n_cmd - c0, 32'd2);

    // Sync value inside the frame is plain data: A5+00+00 = A5
    send5(8'hA5, 8'hA5, 8'h00, 8'h00, 8'hA5);
    drive(8'h00, 1'b0);
    chk("insync_cmd_valid", {31'd0, cmd_valid_o}, 32'd1);
    chk("insync_opcode",    {24'd0, cmd_opcode_o}, 32'hA5);
    drive(8'h00, 1'b0);

`ifdef UART_CMD_PARSER_TIMEOUT_EN
    c0 = n_cmd; e0 = n_errp;
    drive(8'hA5, 1'b1);
    drive(8'h01, 1'b1);
    repeat (10) drive(8'h00, 1'b0);
    chk("tmo_busy_waiting", {31'd0, busy_o}, 32'd1);
    repeat (10) drive(8'h00, 1'b0);
    chk("tmo_busy_dropped", {31'd0, busy_o}, 32'd0);
    chk("tmo_no_err",       n_errp - e0, 32'd0);
    chk("tmo_no_cmd",       n_cmd - c0,  32'd0);
    chk("tmo_opcode_hold",  {24'd0, cmd_opcode_o}, 32'hA5);
    send5(8'hA5, 8'h01, 8'h02, 8'h03, 8'h06);
    drive(8'h00, 1'b0);
    chk("tmo_cmd_valid", {31'd0, cmd_valid_o}, 32'd1);
    chk("tmo_opcode",    {24'd0, cmd_opcode_o}, 32'h01);
    drive(8'h00, 1'b0);
    drive(8'h00, 1'b0);
    chk("tmo_cmd_count", n_cmd - c0, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_uart_cmd_parser
`default_nettype wire
